// File: rtl/nn_sched_pkg.sv
// Shared types and sizing helpers for the nn_share_sched evaluator scheduler.
package nn_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned DEF_IN_W  = 9;
  localparam int unsigned DEF_OUT_W = 8;

  // Settle counter holds SETTLE-1 down to 0; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/nn_share_sched_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any = |valid;
    case (valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/nn_share_sched.sv
// Time-shares one combinational evaluator between two requesters: arbitrate, hold
// operands for a settle interval, then return the captured result with its requester ID.
module nn_share_sched
  import nn_sched_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IN_W-1:0]  req0_in1,
  input  logic [IN_W-1:0]  req0_in2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IN_W-1:0]  req1_in1,
  input  logic [IN_W-1:0]  req1_in2,
  output logic [IN_W-1:0]  nn_in1,
  output logic [IN_W-1:0]  nn_in2,
  input  logic [OUT_W-1:0] nn_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  localparam int              CNT_W    = cnt_width(SETTLE);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]    nn_in1_q, nn_in1_d;
  logic [IN_W-1:0]    nn_in2_q, nn_in2_d;
  logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic               last_q, last_d;

  logic grant;
  logic any_req;
  logic req_hs;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (last_q),
    .grant (grant),
    .any   (any_req)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_hs)           state_d = ST_EVAL;
      ST_EVAL: if (cnt_q == '0)      state_d = ST_RESP;
      ST_RESP: if (rsp_ready)        state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Output decoding; readies are held low throughout reset.
  always_comb begin
    req_hs     = (state_q == ST_IDLE) && !rst && any_req;
    req0_ready = req_hs && !grant;
    req1_ready = req_hs && grant;
    busy       = (state_q != ST_IDLE);
    nn_in1     = nn_in1_q;
    nn_in2     = nn_in2_q;
    rsp_valid  = rsp_valid_q;
    rsp_data   = rsp_data_q;
    rsp_id     = rsp_id_q;
  end

  // Datapath: operands latch only on a request handshake, result only at counter zero.
  always_comb begin
    cnt_d       = cnt_q;
    nn_in1_d    = nn_in1_q;
    nn_in2_d    = nn_in2_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    last_d      = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          nn_in1_d = grant ? req1_in1 : req0_in1;
          nn_in2_d = grant ? req1_in2 : req0_in2;
          rsp_id_d = grant;
          last_d   = grant;
          cnt_d    = CNT_LOAD;
        end
      end
      ST_EVAL: begin
        if (cnt_q == '0) begin
          rsp_data_d  = nn_out;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      nn_in1_q    <= '0;
      nn_in2_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      nn_in1_q    <= nn_in1_d;
      nn_in2_q    <= nn_in2_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_nn_share_sched.sv
// Directed bench for nn_share_sched: one instance at SETTLE=2, one at SETTLE=1,
// each fed by a simple evaluator model with an optional forced result.
module tb_nn_share_sched;

  logic clk;
  logic rst;

  // SETTLE=2 instance signals
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [8:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [8:0] nn_in1, nn_in2;
  logic [7:0] nn_out;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_data;
  logic       nn_ovr_en;
  logic [7:0] nn_ovr;

  // SETTLE=1 instance signals
  logic       s1_req0_valid, s1_req0_ready, s1_req1_valid, s1_req1_ready;
  logic [8:0] s1_req0_in1, s1_req0_in2, s1_req1_in1, s1_req1_in2;
  logic [8:0] s1_nn_in1, s1_nn_in2;
  logic [7:0] s1_nn_out;
  logic       s1_rsp_valid, s1_rsp_ready, s1_rsp_id, s1_busy;
  logic [7:0] s1_rsp_data;

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] nn_f(input logic [8:0] a, input logic [8:0] b);
    return a[7:0] + b[7:0];
  endfunction

  assign nn_out    = nn_ovr_en ? nn_ovr : nn_f(nn_in1, nn_in2);
  assign s1_nn_out = nn_f(s1_nn_in1, s1_nn_in2);

  nn_share_sched #(.IN_W(9), .OUT_W(8), .SETTLE(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .nn_in1(nn_in1), .nn_in2(nn_in2), .nn_out(nn_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  nn_share_sched #(.IN_W(9), .OUT_W(8), .SETTLE(1)) dut_s1 (
    .clk(clk), .rst(rst),
    .req0_valid(s1_req0_valid), .req0_ready(s1_req0_ready),
    .req0_in1(s1_req0_in1), .req0_in2(s1_req0_in2),
    .req1_valid(s1_req1_valid), .req1_ready(s1_req1_ready),
    .req1_in1(s1_req1_in1), .req1_in2(s1_req1_in2),
    .nn_in1(s1_nn_in1), .nn_in2(s1_nn_in2), .nn_out(s1_nn_out),
    .rsp_valid(s1_rsp_valid), .rsp_ready(s1_rsp_ready),
    .rsp_data(s1_rsp_data), .rsp_id(s1_rsp_id), .busy(s1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_id;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_in1 = 0; req0_in2 = 0; req1_in1 = 0; req1_in2 = 0;
    nn_ovr_en = 0; nn_ovr = 0;
    s1_req0_valid = 0; s1_req1_valid = 0; s1_rsp_ready = 0;
    s1_req0_in1 = 0; s1_req0_in2 = 0; s1_req1_in1 = 0; s1_req1_in2 = 0;

    // Reset values, readies low even with valids offered
    tick();
    req0_valid = 1; req1_valid = 1;
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_nn_in1", nn_in1, 0);
    check("rst_nn_in2", nn_in2, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    req0_valid = 0; req1_valid = 0;
    rst = 0;
    tick();

    // Single request from req0, forced evaluator result 0x3C
    req0_valid = 1; req0_in1 = 9'h0A5; req0_in2 = 9'h013;
    nn_ovr_en = 1; nn_ovr = 8'h3C;
    #1;
    check("t1_req0_ready", req0_ready, 1);
    check("t1_req1_ready", req1_ready, 0);
    tick();                                  // edge T
    req0_valid = 0;
    check("t1_nn_in1", nn_in1, 9'h0A5);
    check("t1_nn_in2", nn_in2, 9'h013);
    check("t1_busy_T", busy, 1);
    check("t1_valid_T", rsp_valid, 0);
    tick();                                  // T+1
    check("t1_valid_T1", rsp_valid, 0);
    check("t1_busy_T1", busy, 1);
    tick();                                  // T+2
    check("t1_valid_T2", rsp_valid, 1);
    check("t1_data", rsp_data, 8'h3C);
    check("t1_id", rsp_id, 0);
    check("t1_busy_T2", busy, 1);
    rsp_ready = 1;
    tick();                                  // T+3 response handshake
    check("t1_valid_T3", rsp_valid, 0);
    check("t1_busy_T3", busy, 0);
    rsp_ready = 0; nn_ovr_en = 0;

    // Tie after reset: alternate 0,1,0,1 at a 4-cycle period
    rst = 1; #1; rst = 0;
    req0_valid = 1; req0_in1 = 9'h101; req0_in2 = 9'h002;
    req1_valid = 1; req1_in1 = 9'h0F0; req1_in2 = 9'h011;
    rsp_ready = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_id = k[0];
      check("tie_req0_ready", req0_ready, !exp_id);
      check("tie_req1_ready", req1_ready, exp_id);
      tick();
      check("tie_nn_in1", nn_in1, exp_id ? 9'h0F0 : 9'h101);
      tick();
      check("tie_valid_early", rsp_valid, 0);
      tick();
      check("tie_valid", rsp_valid, 1);
      check("tie_id", rsp_id, exp_id);
      check("tie_data", rsp_data, exp_id ? 8'h01 : 8'h03);
      tick();
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;

    // Back-pressure: 10 cycles in RESP with a competing request pending
    req1_valid = 1; req1_in1 = 9'h1FF; req1_in2 = 9'h0AA;
    #1;
    check("bp_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_in1 = 9'h033; req0_in2 = 9'h044;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 8'hA9);
      check("bp_id", rsp_id, 1);
      check("bp_req0_ready", req0_ready, 0);
      check("bp_nn_in1", nn_in1, 9'h1FF);
      tick();
    end
    rsp_ready = 1; nn_ovr_en = 1; nn_ovr = 8'h11;
    tick();
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_busy", busy, 0);
    check("bp_release_ready", req0_ready, 1);
    rsp_ready = 0;

    // Operand hold: evaluator output changes mid-EVAL
    tick();                                  // edge T, req0 accepted
    req0_valid = 0;
    check("oh_nn_in1_T", nn_in1, 9'h033);
    check("oh_nn_in2_T", nn_in2, 9'h044);
    tick();                                  // T+1, counter at zero
    check("oh_nn_in1_T1", nn_in1, 9'h033);
    check("oh_valid_T1", rsp_valid, 0);
    nn_ovr = 8'h22;
    tick();                                  // T+2 capture
    check("oh_valid", rsp_valid, 1);
    check("oh_data", rsp_data, 8'h22);
    check("oh_id", rsp_id, 0);
    check("oh_nn_in1_T2", nn_in1, 9'h033);
    check("oh_nn_in2_T2", nn_in2, 9'h044);
    nn_ovr = 8'h55;
    tick();
    check("oh_data_held", rsp_data, 8'h22);
    rsp_ready = 1;
    tick();
    rsp_ready = 0; nn_ovr_en = 0;

    // Reset one cycle after a request handshake
    req0_valid = 1; req0_in1 = 9'h077; req0_in2 = 9'h001;
    tick();                                  // edge T
    req0_valid = 0;
    tick();                                  // T+1
    #2;
    rst = 1;
    #1;
    check("mr_busy", busy, 0);
    check("mr_nn_in1", nn_in1, 0);
    check("mr_nn_in2", nn_in2, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_rsp_data", rsp_data, 0);
    check("mr_rsp_id", rsp_id, 0);
    tick();
    #2;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_no_rsp", rsp_valid, 0);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    check("mr_tie_req0", req0_ready, 1);
    check("mr_tie_req1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;

    // SETTLE=1: accept / respond / accept on a 3-cycle period
    s1_rsp_ready = 1;
    s1_req1_valid = 1; s1_req1_in1 = 9'h010; s1_req1_in2 = 9'h020;
    #1;
    check("s1_ready_0", s1_req1_ready, 1);
    tick();                                  // edge T
    check("s1_busy_T", s1_busy, 1);
    check("s1_valid_T", s1_rsp_valid, 0);
    tick();                                  // T+1
    check("s1_valid_T1", s1_rsp_valid, 1);
    check("s1_data", s1_rsp_data, 8'h30);
    check("s1_id", s1_rsp_id, 1);
    check("s1_ready_T1", s1_req1_ready, 0);
    tick();                                  // T+2 response handshake
    check("s1_valid_T2", s1_rsp_valid, 0);
    check("s1_ready_T2", s1_req1_ready, 1);
    tick();                                  // T+3 second accept
    check("s1_busy_T3", s1_busy, 1);
    check("s1_valid_T3", s1_rsp_valid, 0);
    tick();                                  // T+4
    check("s1_valid_T4", s1_rsp_valid, 1);
    s1_req1_valid = 0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
